// File: rtl/fft_frame_buffer.sv
// rtl/fft_frame_buffer.sv - ping-pong sample-to-frame packer feeding the FFT core
module fft_frame_buffer #(
   parameter int sample_size = 32,
   parameter int buffer_size = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush,
   input  logic signed [sample_size-1:0]        sample_in,
   input  logic                                 sample_valid,
   output logic                                 sample_ready,
   output logic [buffer_size*sample_size-1:0]   frame_out,
   output logic                                 frame_valid,
   input  logic                                 frame_ready
);

   localparam int IW = $clog2(buffer_size);

   // two banks of sample registers; frame_out is a pure mux of these
   logic [sample_size-1:0] bank0_q [buffer_size];
   logic [sample_size-1:0] bank1_q [buffer_size];

   logic          wr_bank_q, wr_bank_d;
   logic [IW-1:0] wr_idx_q,  wr_idx_d;
   logic          rd_bank_q, rd_bank_d;
   logic [1:0]    full_q,    full_d;

   logic accept;
   logic release_frame;
   logic last_slot;

   assign sample_ready  = !full_q[wr_bank_q] && !flush;
   assign accept        = sample_valid && sample_ready;
   assign frame_valid   = full_q[rd_bank_q];
   assign release_frame = frame_valid && frame_ready;
   assign last_slot     = (wr_idx_q == IW'(buffer_size - 1));

   // next-state for write pointer, read pointer and bank-full flags
   always_comb begin
      wr_bank_d = wr_bank_q;
      wr_idx_d  = wr_idx_q;
      rd_bank_d = rd_bank_q;
      full_d    = full_q;

      // a release can only target a full bank, an accept only a non-full one,
      // so both updates to full_d never hit the same bit
      if (release_frame) begin
         full_d[rd_bank_q] = 1'b0;
         rd_bank_d         = !rd_bank_q;
      end

      if (flush) begin
         wr_idx_d = '0;
      end else if (accept) begin
         if (last_slot) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = !wr_bank_q;
            wr_idx_d          = '0;
         end else begin
            wr_idx_d = wr_idx_q + 1'b1;
         end
      end
   end

   // control state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank_q <= 1'b0;
         wr_idx_q  <= '0;
         rd_bank_q <= 1'b0;
         full_q    <= 2'b00;
      end else begin
         wr_bank_q <= wr_bank_d;
         wr_idx_q  <= wr_idx_d;
         rd_bank_q <= rd_bank_d;
         full_q    <= full_d;
      end
   end

   // sample storage: accepted sample written bit-exact into the active bank
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < buffer_size; i++) begin
            bank0_q[i] <= '0;
            bank1_q[i] <= '0;
         end
      end else if (accept) begin
         if (wr_bank_q) begin
            bank1_q[wr_idx_q] <= sample_in;
         end else begin
            bank0_q[wr_idx_q] <= sample_in;
         end
      end
   end

   // flat frame bus: slot j comes from register j of the read bank
   for (genvar j = 0; j < buffer_size; j++) begin : g_slot
      assign frame_out[j*sample_size +: sample_size] = rd_bank_q ? bank1_q[j] : bank0_q[j];
   end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// tb/tb_fft_frame_buffer.sv - directed self-checking bench for fft_frame_buffer
module tb_fft_frame_buffer;

   localparam int SS = 32;
   localparam int BS = 16;

   logic                 clk;
   logic                 rst_n;
   logic                 flush;
   logic signed [SS-1:0] sample_in;
   logic                 sample_valid;
   logic                 sample_ready;
   logic [BS*SS-1:0]     frame_out;
   logic                 frame_valid;
   logic                 frame_ready;

   int checks;
   int errors;

   fft_frame_buffer #(.sample_size(SS), .buffer_size(BS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .sample_in    (sample_in),
      .sample_valid (sample_valid),
      .sample_ready (sample_ready),
      .frame_out    (frame_out),
      .frame_valid  (frame_valid),
      .frame_ready  (frame_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [BS*SS-1:0] make_frame(input int base);
      logic [BS*SS-1:0] f;
      f = '0;
      for (int j = 0; j < BS; j++) f[j*SS +: SS] = SS'(base + j);
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; sample_in = '0; sample_valid = 1'b0; frame_ready = 1'b0;
      #2;
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", sample_ready); end
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
      checks++;
      if (frame_out !== '0) begin errors++; $display("FAIL reset_frame got %h want 0", frame_out); end
      tick(); tick();
      rst_n = 1'b1;
      #1;
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b want 1", sample_ready); end
   endtask

   task automatic test_stream();
      frame_ready = 1'b1;
      for (int i = 0; i < BS; i++) begin
         sample_in = SS'(i); sample_valid = 1'b1;
         #1;
         checks++;
         if (sample_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, sample_ready); end
         tick();
      end
      sample_valid = 1'b0;
      #1;
      checks++;
      if (frame_valid !== 1'b1) begin errors++; $display("FAIL stream_valid got %b want 1", frame_valid); end
      checks++;
      if (frame_out !== make_frame(0)) begin errors++; $display("FAIL stream_frame got %h want %h", frame_out, make_frame(0)); end
      tick();
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL stream_release got %b want 0", frame_valid); end
      frame_ready = 1'b0;
   endtask

   task automatic test_stall();
      frame_ready = 1'b0;
      for (int i = 0; i < 2*BS; i++) begin
         sample_in = SS'(i); sample_valid = 1'b1;
         #1;
         checks++;
         if (sample_ready !== 1'b1) begin errors++; $display("FAIL stall_fill_ready[%0d] got %b want 1", i, sample_ready); end
         tick();
      end
      sample_in = SS'(32); sample_valid = 1'b1;
      #1;
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %b want 0", sample_ready); end
      checks++;
      if (frame_out !== make_frame(0)) begin errors++; $display("FAIL stall_frame0 got %h want %h", frame_out, make_frame(0)); end
      tick(); tick();
      checks++;
      if (sample_ready !== 1'b0 || frame_valid !== 1'b1) begin
         errors++; $display("FAIL stall_hold ready %b valid %b want 0 1", sample_ready, frame_valid);
      end
      checks++;
      if (frame_out !== make_frame(0)) begin errors++; $display("FAIL stall_hold_frame got %h want %h", frame_out, make_frame(0)); end
      frame_ready = 1'b1;
      #1;
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL stall_no_comb_path got %b want 0", sample_ready); end
      tick();
      frame_ready = 1'b0;
      #1;
      checks++;
      if (frame_out !== make_frame(16)) begin errors++; $display("FAIL stall_frame1 got %h want %h", frame_out, make_frame(16)); end
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL stall_unblock got %b want 1", sample_ready); end
      tick();
      for (int i = 33; i < 48; i++) begin
         sample_in = SS'(i); sample_valid = 1'b1;
         #1;
         checks++;
         if (sample_ready !== 1'b1) begin errors++; $display("FAIL stall_refill_ready[%0d] got %b want 1", i, sample_ready); end
         tick();
      end
      sample_valid = 1'b0;
      frame_ready = 1'b1;
      #1;
      checks++;
      if (frame_out !== make_frame(16)) begin errors++; $display("FAIL stall_pending got %h want %h", frame_out, make_frame(16)); end
      tick();
      checks++;
      if (frame_valid !== 1'b1 || frame_out !== make_frame(32)) begin
         errors++; $display("FAIL stall_frame2 valid %b got %h want 1 %h", frame_valid, frame_out, make_frame(32));
      end
      tick();
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL stall_drain got %b want 0", frame_valid); end
      frame_ready = 1'b0;
   endtask

   task automatic test_signed();
      logic [SS-1:0] vals [3];
      logic [SS-1:0] exp_s [3];
      vals[0] = 32'hFFFF_FFFF; vals[1] = 32'h8000_0000; vals[2] = 32'h7FFF_FFFF;
      exp_s[0] = 32'hFFFF_FFFF; exp_s[1] = 32'h8000_0000; exp_s[2] = 32'h7FFF_FFFF;
      frame_ready = 1'b0;
      for (int i = 0; i < BS; i++) begin
         sample_in = (i < 3) ? vals[i] : '0; sample_valid = 1'b1;
         tick();
      end
      sample_valid = 1'b0;
      #1;
      for (int j = 0; j < 3; j++) begin
         checks++;
         if (frame_out[j*SS +: SS] !== exp_s[j]) begin
            errors++; $display("FAIL signed_slot[%0d] got %h want %h", j, frame_out[j*SS +: SS], exp_s[j]);
         end
      end
      checks++;
      if (frame_out[BS*SS-1:3*SS] !== '0) begin errors++; $display("FAIL signed_zeros got %h want 0", frame_out[BS*SS-1:3*SS]); end
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
   endtask

   task automatic test_flush();
      frame_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         sample_in = SS'(50 + i); sample_valid = 1'b1;
         tick();
      end
      sample_in = SS'(99); sample_valid = 1'b1; flush = 1'b1;
      #1;
      checks++;
      if (sample_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", sample_ready); end
      tick();
      flush = 1'b0;
      for (int i = 0; i < BS; i++) begin
         sample_in = SS'(100 + i); sample_valid = 1'b1;
         #1;
         checks++;
         if (frame_valid !== 1'b0) begin errors++; $display("FAIL flush_early_valid[%0d] got %b want 0", i, frame_valid); end
         tick();
      end
      sample_valid = 1'b0;
      #1;
      checks++;
      if (frame_valid !== 1'b1 || frame_out !== make_frame(100)) begin
         errors++; $display("FAIL flush_frame valid %b got %h want 1 %h", frame_valid, frame_out, make_frame(100));
      end
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      frame_ready = 1'b0;
      for (int i = 0; i < BS + 7; i++) begin
         sample_in = SS'(200 + i); sample_valid = 1'b1;
         tick();
      end
      sample_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", frame_valid); end
      checks++;
      if (frame_out !== '0) begin errors++; $display("FAIL areset_frame got %h want 0", frame_out); end
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got %b want 1", sample_ready); end
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < BS; i++) begin
         sample_in = SS'(400 + i); sample_valid = 1'b1;
         tick();
      end
      sample_valid = 1'b0;
      #1;
      checks++;
      if (frame_valid !== 1'b1 || frame_out !== make_frame(400)) begin
         errors++; $display("FAIL areset_newframe valid %b got %h want 1 %h", frame_valid, frame_out, make_frame(400));
      end
      frame_ready = 1'b1;
      tick();
      frame_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      frame_ready = 1'b0;
      for (int i = 0; i < BS; i++) begin
         sample_in = SS'(500 + i); sample_valid = 1'b1;
         tick();
      end
      for (int i = 0; i < BS - 1; i++) begin
         sample_in = SS'(600 + i); sample_valid = 1'b1;
         #1;
         checks++;
         if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, sample_ready); end
         tick();
      end
      sample_in = SS'(615); sample_valid = 1'b1; frame_ready = 1'b1;
      #1;
      checks++;
      if (sample_ready !== 1'b1 || frame_out !== make_frame(500)) begin
         errors++; $display("FAIL b2b_before ready %b got %h want 1 %h", sample_ready, frame_out, make_frame(500));
      end
      tick();
      sample_valid = 1'b0; frame_ready = 1'b0;
      #1;
      checks++;
      if (frame_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", frame_valid); end
      checks++;
      if (frame_out !== make_frame(600)) begin errors++; $display("FAIL b2b_frame got %h want %h", frame_out, make_frame(600)); end
      checks++;
      if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_ready got %b want 1", sample_ready); end
      frame_ready = 1'b1;
      tick();
      checks++;
      if (frame_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", frame_valid); end
      frame_ready = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      tick();
      test_stream();
      test_stall();
      test_signed();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
